serial_tx_fifo16: RTL

- Byte-wide UART transmitter for the KCPSM3 output-port side.
- It is the send-direction partner of the team's serial receive path.
- PicoBlaze OUTPUT strobes write bytes into a 16-deep FIFO. The block serialises them as 8N1 frames on serial_out, using a shared 16x-baud enable.
- It sits between the processor port decode and the device pin.

---
 rtl/serial_tx_fifo16_pkg.sv | 6 +
 rtl/serial_tx_fifo16_fifo.sv | 47 ++++
 rtl/serial_tx_fifo16.sv | 93 +++++++++
 3 files changed

// File: rtl/serial_tx_fifo16_pkg.sv
// serial_tx_fifo16_pkg: shared FSM encoding and frame constants for the UART transmit path
package serial_tx_fifo16_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;
endpackage

// File: rtl/serial_tx_fifo16_fifo.sv
// sync_fifo16: circular byte FIFO with occupancy count and registered fill flags
module sync_fifo16 #(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       half_full,
    output logic       data_present
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          wr_ok, rd_ok;

    // full is judged on the pre-pop count, so a write into a full FIFO is lost even alongside a pop
    assign wr_ok   = write && count != CW'(DEPTH);
    assign rd_ok   = read && count != '0;
    assign count_d = (wr_ok && !rd_ok) ? count + 1'b1 : (rd_ok && !wr_ok) ? count - 1'b1 : count;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK)
        if (wr_ok) mem[wr_ptr] <= din;

    always_ff @(posedge CLK or posedge CLR)
        if (CLR) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            half_full    <= 1'b0;
            data_present <= 1'b0;
        end else begin
            wr_ptr       <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr       <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count        <= count_d;
            full         <= count_d == CW'(DEPTH);
            half_full    <= count_d >= CW'(DEPTH / 2);
            data_present <= count_d != '0;
        end
endmodule

// File: rtl/serial_tx_fifo16.sv
// serial_tx_fifo16: queues PicoBlaze output bytes and sends them as 8N1 frames
// paced by a shared 16x-baud enable
module serial_tx_fifo16
    import serial_tx_fifo16_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] data_in,
    input  logic       write_buffer,
    input  logic       en_16_x_baud,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       buffer_half_full,
    output logic       buffer_data_present,
    output logic       tx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    tx_state_t     state, state_d;
    logic [TW-1:0] tick, tick_d;
    logic [BW-1:0] bit_idx, bit_d;
    logic [7:0]    shift, shift_d, fifo_dout;
    logic          pop, bit_end, serial_d;

    sync_fifo16 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK         (CLK),
        .CLR         (CLR),
        .write       (write_buffer),
        .read        (pop),
        .din         (data_in),
        .dout        (fifo_dout),
        .full        (buffer_full),
        .half_full   (buffer_half_full),
        .data_present(buffer_data_present)
    );

    assign bit_end = en_16_x_baud && tick == TW'(OVERSAMPLE - 1);

    always_ff @(posedge CLK or posedge CLR)
        if (CLR) begin
            state      <= IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_d;
            tick       <= tick_d;
            bit_idx    <= bit_d;
            shift      <= shift_d;
            serial_out <= serial_d;
        end

    always_comb begin
        state_d = state;
        tick_d  = tick;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        if (state == IDLE) begin
            if (en_16_x_baud && buffer_data_present) begin
                pop     = 1'b1;
                shift_d = fifo_dout;
                state_d = START;
                tick_d  = '0;
            end
        end else if (en_16_x_baud) begin
            tick_d = bit_end ? '0 : tick + 1'b1;
            if (bit_end)
                case (state)
                    START: begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                    DATA: begin
                        shift_d = shift >> 1;
                        bit_d   = bit_idx + 1'b1;
                        state_d = (bit_idx == BW'(DATA_BITS - 1)) ? STOP : DATA;
                    end
                    default: state_d = IDLE;
                endcase
        end
    end

    // the line level is computed from the next state so serial_out itself is a plain register
    always_comb begin
        serial_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        tx_busy  = state != IDLE;
    end
endmodule
